// File: rtl/dds_wave_synth.sv
// Multi-waveform DDS: phase accumulator stepped by the sample strobe, double-buffered config,
// three-stage output pipeline (phase offset, waveform shaping with quarter-wave sine, attenuation).
module dds_wave_synth #(
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_en,
  input  logic                     phase_sync,
  input  logic                     cfg_load,
  input  logic [ACC_W-1:0]         cfg_freq,
  input  logic [ACC_W-1:0]         cfg_phase,
  input  logic [1:0]               cfg_wave,
  input  logic [4:0]               cfg_atten,
  output logic                     cfg_pending,
  output logic signed [DATA_W-1:0] dataout,
  output logic                     dout_valid
);

  localparam int     QA     = ADDR_W - 2;
  localparam int     QN     = 2 ** QA;
  localparam longint PI_Q30 = 64'sd3373259426;
  localparam longint MAX_L  = (longint'(1) <<< (DATA_W - 1)) - 1;
  localparam logic signed [DATA_W-1:0] MAX_S = {1'b0, {(DATA_W-1){1'b1}}};

  // Quarter-wave entry sin((i+0.5)*pi/2/QN)*MAX, rounded; Taylor series in Q30 fixed point.
  function automatic logic [DATA_W-1:0] f_sin_entry(input int idx);
    longint x, x2, term, sum, v;
    x    = (longint'(2 * idx + 1) * PI_Q30) / longint'(4 * QN);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 10; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    v = (sum * MAX_L + (longint'(1) <<< 29)) >>> 30;
    return DATA_W'(v);
  endfunction

  function automatic logic signed [DATA_W-1:0] f_atten(input logic signed [DATA_W-1:0] w,
                                                       input logic [4:0] a);
    if (int'(a) >= DATA_W) return '0;
    return w >>> a;
  endfunction

  logic [DATA_W-1:0] w_rom [QN];
  for (genvar g = 0; g < QN; g++) begin : g_rom
    assign w_rom[g] = f_sin_entry(g);
  end

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_freq_a, r_phase_a, r_freq_s, r_phase_s;
  logic [1:0]       r_wave_a, r_wave_s;
  logic [4:0]       r_atten_a, r_atten_s;
  logic             r_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_freq_a  <= '0;
      r_phase_a <= '0;
      r_wave_a  <= '0;
      r_atten_a <= '0;
      r_freq_s  <= '0;
      r_phase_s <= '0;
      r_wave_s  <= '0;
      r_atten_s <= '0;
      r_pending <= 1'b0;
    end else begin
      if (sample_en && r_pending) begin
        r_freq_a  <= r_freq_s;
        r_phase_a <= r_phase_s;
        r_wave_a  <= r_wave_s;
        r_atten_a <= r_atten_s;
      end
      if (cfg_load) begin
        r_freq_s  <= cfg_freq;
        r_phase_s <= cfg_phase;
        r_wave_s  <= cfg_wave;
        r_atten_s <= cfg_atten;
      end
      if (cfg_load)       r_pending <= 1'b1;
      else if (sample_en) r_pending <= 1'b0;
    end
  end

  // Accumulator steps with the pre-swap frequency.
  logic r_vld_p0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_vld_p0 <= 1'b0;
    end else begin
      if (sample_en) r_acc <= phase_sync ? '0 : r_acc + r_freq_a;
      r_vld_p0 <= sample_en;
    end
  end

  // Stage 1: phase offset; wave/atten frozen with the sample.
  logic [ACC_W-1:0] r_ph_p1;
  logic [1:0]       r_wave_p1;
  logic [4:0]       r_atten_p1;
  logic             r_vld_p1;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ph_p1    <= '0;
      r_wave_p1  <= '0;
      r_atten_p1 <= '0;
      r_vld_p1   <= 1'b0;
    end else begin
      r_ph_p1    <= r_acc + r_phase_a;
      r_wave_p1  <= r_wave_a;
      r_atten_p1 <= r_atten_a;
      r_vld_p1   <= r_vld_p0;
    end
  end

  logic [ADDR_W-1:0]        w_p;
  logic [1:0]               w_q;
  logic [QA-1:0]            w_i, w_sin_idx;
  logic [DATA_W-1:0]        w_rom_v, w_tri_u, w_tri_t;
  logic signed [DATA_W-1:0] w_sin, w_wave;
  logic                     w_unused_ph;

  assign w_p         = r_ph_p1[ACC_W-1 -: ADDR_W];
  assign w_q         = w_p[ADDR_W-1 -: 2];
  assign w_i         = w_p[QA-1:0];
  assign w_sin_idx   = w_q[0] ? ~w_i : w_i;
  assign w_rom_v     = w_rom[w_sin_idx];
  assign w_sin       = w_q[1] ? -$signed(w_rom_v) : $signed(w_rom_v);
  assign w_tri_u     = r_ph_p1[ACC_W-2 -: DATA_W];
  assign w_tri_t     = r_ph_p1[ACC_W-1] ? ~w_tri_u : w_tri_u;
  assign w_unused_ph = ^r_ph_p1[ACC_W-DATA_W-2:0];

  always_comb begin
    w_wave = '0;
    case (r_wave_p1)
      2'd0:    w_wave = w_sin;
      2'd1:    w_wave = r_ph_p1[ACC_W-1] ? -MAX_S : MAX_S;
      2'd2:    w_wave = {~w_tri_t[DATA_W-1], w_tri_t[DATA_W-2:0]};
      default: w_wave = {~r_ph_p1[ACC_W-1], r_ph_p1[ACC_W-2 -: DATA_W-1]};
    endcase
  end

  // Stage 2: registered waveform (ROM read lands here).
  logic signed [DATA_W-1:0] r_w_p2;
  logic [4:0]               r_atten_p2;
  logic                     r_vld_p2;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_w_p2     <= '0;
      r_atten_p2 <= '0;
      r_vld_p2   <= 1'b0;
    end else begin
      r_w_p2     <= w_wave;
      r_atten_p2 <= r_atten_p1;
      r_vld_p2   <= r_vld_p1;
    end
  end

  // Stage 3: attenuation; output holds between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataout    <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (r_vld_p2) dataout <= f_atten(r_w_p2, r_atten_p2);
      dout_valid <= r_vld_p2;
    end
  end

  assign cfg_pending = r_pending;

endmodule

// File: tb/tb_dds_wave_synth.sv
// Directed bench for dds_wave_synth: behavioural model pushes expected samples with their due cycle.
module tb_dds_wave_synth;

  localparam int  ACC_W  = 24;
  localparam int  ADDR_W = 10;
  localparam int  DATA_W = 16;
  localparam int  MAX    = 32767;
  localparam real PI     = 3.14159265358979323846;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     sample_en = 1'b0;
  logic                     phase_sync = 1'b0;
  logic                     cfg_load = 1'b0;
  logic [ACC_W-1:0]         cfg_freq = '0;
  logic [ACC_W-1:0]         cfg_phase = '0;
  logic [1:0]               cfg_wave = '0;
  logic [4:0]               cfg_atten = '0;
  logic                     cfg_pending;
  logic signed [DATA_W-1:0] dataout;
  logic                     dout_valid;

  dds_wave_synth #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .phase_sync(phase_sync),
    .cfg_load(cfg_load), .cfg_freq(cfg_freq), .cfg_phase(cfg_phase), .cfg_wave(cfg_wave),
    .cfg_atten(cfg_atten), .cfg_pending(cfg_pending), .dataout(dataout), .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int val; int due; } exp_t;
  exp_t q[$];

  logic [ACC_W-1:0] m_acc, m_freq, m_phase, s_freq, s_phase;
  logic [1:0]       m_wave, s_wave;
  logic [4:0]       m_atten, s_atten;
  bit               m_pend;

  task automatic chk(input string tag, input integer got, input integer exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int expw(input logic [ACC_W-1:0] ph, input logic [1:0] w, input logic [4:0] a);
    int  v, p, x;
    real s;
    case (w)
      2'd0: begin
        p = int'(ph[ACC_W-1 -: ADDR_W]);
        s = $sin((real'(p) + 0.5) * 2.0 * PI / 1024.0) * real'(MAX);
        if (s < 0.0) v = -$rtoi(-s + 0.5);
        else         v = $rtoi(s + 0.5);
      end
      2'd1: v = ph[ACC_W-1] ? -MAX : MAX;
      2'd2: begin
        x = int'(ph[ACC_W-1 -: DATA_W+1]);
        v = (x < 65536) ? x - 32768 : 32767 - (x - 65536);
      end
      default: v = int'(ph[ACC_W-1 -: DATA_W]) - 32768;
    endcase
    if (a >= 5'd16) return 0;
    return v >>> a;
  endfunction

  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sample", $signed(dataout), e.val);
        chk("latency", cyc, e.due);
      end
    end
  end

  task automatic step(input bit se, input bit sync, input bit ld);
    logic [ACC_W-1:0] na;
    exp_t e;
    if (se) begin
      na = sync ? '0 : m_acc + m_freq;
      if (m_pend) begin
        m_freq = s_freq; m_phase = s_phase; m_wave = s_wave; m_atten = s_atten; m_pend = 0;
      end
      m_acc = na;
      e.val = expw(m_acc + m_phase, m_wave, m_atten);
      e.due = cyc + 4;
      q.push_back(e);
    end
    if (ld) begin
      s_freq = cfg_freq; s_phase = cfg_phase; s_wave = cfg_wave; s_atten = cfg_atten; m_pend = 1;
    end
    sample_en = se; phase_sync = sync; cfg_load = ld;
    @(posedge clk); #1;
    sample_en = 0; phase_sync = 0; cfg_load = 0;
  endtask

  task automatic set_cfg(input logic [ACC_W-1:0] f, input logic [ACC_W-1:0] p,
                         input logic [1:0] w, input logic [4:0] a);
    cfg_freq = f; cfg_phase = p; cfg_wave = w; cfg_atten = a;
  endtask

  task automatic strobes(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0);
      for (int j = 0; j < gap; j++) step(0, 0, 0);
    end
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (q.size() > 0 && k < 30) begin
      step(0, 0, 0);
      k++;
    end
    step(0, 0, 0);
    chk(tag, q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    q.delete();
    m_acc = '0; m_freq = '0; m_phase = '0; m_wave = '0; m_atten = '0;
    s_freq = '0; s_phase = '0; s_wave = '0; s_atten = '0; m_pend = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    // T1 reset state, then sine at zero frequency
    do_reset(2);
    chk("rst_dataout", dataout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_pending", cfg_pending, 0);
    strobes(2, 3);
    drain("t1_drain");

    // T2 sine sweep through all 1024 phases and back to the start
    set_cfg(24'd1 << (ACC_W - ADDR_W), '0, 2'd0, 5'd0);
    step(0, 0, 1);
    chk("t2_pending_set", cfg_pending, 1);
    step(1, 1, 0);
    chk("t2_pending_clr", cfg_pending, 0);
    strobes(1025, 3);
    drain("t2_drain");

    // T3 square quarter steps, saw eighth steps back-to-back, triangle with offset
    set_cfg(24'd1 << (ACC_W - 2), '0, 2'd1, 5'd0);
    step(0, 0, 1);
    step(1, 1, 0);
    strobes(8, 1);
    set_cfg(24'd1 << (ACC_W - 3), '0, 2'd3, 5'd0);
    step(0, 0, 1);
    step(1, 1, 0);
    strobes(17, 0);
    set_cfg(24'h123457, 24'h400000, 2'd2, 5'd1);
    step(0, 0, 1);
    strobes(40, 0);
    set_cfg(24'h0BEEF1, 24'h9A5A5A, 2'd0, 5'd2);
    step(0, 0, 1);
    strobes(30, 2);
    drain("t3_drain");

    // T4 modulo wrap with all-ones increment, then phase_sync
    set_cfg({ACC_W{1'b1}}, '0, 2'd3, 5'd0);
    step(0, 0, 1);
    step(1, 1, 0);
    strobes(6, 1);
    step(1, 1, 0);
    strobes(3, 0);
    drain("t4_drain");

    // T5 load coinciding with a strobe, then attenuation
    set_cfg(24'd1 << (ACC_W - 2), '0, 2'd1, 5'd0);
    step(0, 0, 1);
    step(1, 1, 0);
    strobes(2, 1);
    set_cfg(24'd1 << (ACC_W - 2), 24'h100000, 2'd2, 5'd0);
    step(1, 0, 1);
    chk("t5_pending_held", cfg_pending, 1);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("t5_pending_applied", cfg_pending, 0);
    strobes(3, 1);
    set_cfg(24'd1 << (ACC_W - 2), '0, 2'd1, 5'd3);
    step(0, 0, 1);
    step(1, 1, 0);
    strobes(4, 1);
    set_cfg(24'd1 << (ACC_W - 2), '0, 2'd1, 5'd20);
    step(0, 0, 1);
    strobes(3, 1);
    drain("t5_drain");

    // T6 reset one cycle after a strobe kills the in-flight sample
    set_cfg(24'd1 << 20, '0, 2'd1, 5'd0);
    step(0, 0, 1);
    strobes(3, 3);
    drain("t6_pre_drain");
    step(1, 0, 1);
    do_reset(1);
    chk("t6_dataout", dataout, 0);
    chk("t6_valid", dout_valid, 0);
    chk("t6_pending", cfg_pending, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    strobes(2, 2);
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
